// File: rtl/ctrl_pkg.sv
// Shared definitions for the microcontroller control unit: opcode classes,
// ALU operation codes, run-state encoding and the control vector layout.
package ctrl_pkg;

   // Opcode classes, matched against Opcode[5:2]. An ALU R-type instruction is
   // recognised from Opcode[5] alone, so only bit 3 of OPC_ALU is meaningful.
   localparam logic [3:0] OPC_ALU = 4'b1000;
   localparam logic [3:0] OPC_LI  = 4'b0000;
   localparam logic [3:0] OPC_J   = 4'b0100;
   localparam logic [3:0] OPC_JZ  = 4'b0101;
   localparam logic [3:0] OPC_JNZ = 4'b0110;

   // Class 0111 holds only the HALT encoding; the other three words in it are illegal.
   localparam logic [3:0] OPC_SYS  = 4'b0111;
   localparam logic [5:0] OPC_HALT = 6'b011100;

   // ALU operation select. R-type instructions pass Opcode[4:2] straight through,
   // so these names only document the datapath ALU's own encoding.
   localparam logic [2:0] ALU_PASSB = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b001;
   localparam logic [2:0] ALU_SUB   = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_XOR   = 3'b101;
   localparam logic [2:0] ALU_SLT   = 3'b110;
   localparam logic [2:0] ALU_NOT   = 3'b111;

   // Run-state encoding.
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_TRAP = 2'd2
   } state_t;

   // Datapath control vector.
   typedef struct packed {
      logic       s_inc;
      logic       s_inm;
      logic       we;
      logic       wez;
      logic [2:0] alu_op;
   } ctrl_t;

   // Control vector while reset is asserted: PC advances, nothing is written.
   localparam ctrl_t CTRL_RESET = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0, wez: 1'b0, alu_op: ALU_PASSB};

   // Control vector in HALT and TRAP: PC reloads from the instruction, nothing is written.
   localparam ctrl_t CTRL_STOP  = '{s_inc: 1'b0, s_inm: 1'b0, we: 1'b0, wez: 1'b0, alu_op: ALU_PASSB};

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decoder: maps the 6-bit opcode and the zero flag to
// the control vector used while the CPU is running, and flags the HALT and
// illegal encodings for the run-state machine.
module control_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] Opcode,
   input  logic       zero,
   output ctrl_t      ctrl,
   output logic       is_halt,
   output logic       is_illegal
);

   // Decode one instruction; defaults describe a harmless "advance PC" row.
   always_comb begin
      ctrl       = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0, wez: 1'b0, alu_op: ALU_PASSB};
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      if (Opcode[5]) begin
         ctrl.alu_op = Opcode[4:2];
         ctrl.we     = 1'b1;
         ctrl.wez    = 1'b1;
      end else begin
         case (Opcode[5:2])
            OPC_LI: begin
               ctrl.s_inm = 1'b1;
               ctrl.we    = 1'b1;
            end
            OPC_J:   ctrl.s_inc = 1'b0;
            OPC_JZ:  ctrl.s_inc = ~zero;
            OPC_JNZ: ctrl.s_inc = zero;
            OPC_SYS: begin
               if (Opcode == OPC_HALT) begin
                  ctrl.s_inc = 1'b0;
                  is_halt    = 1'b1;
               end else begin
                  is_illegal = 1'b1;
               end
            end
            default: is_illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/control_unit.sv
// Control unit for the single-cycle microcontroller datapath. Decodes the
// opcode combinationally, tracks a RUN/HALT/TRAP run state and forces safe
// controls during reset, HALT and TRAP.
// Optional feature: define CTRL_PERF_EN to build the retired/taken counters;
// otherwise both counter outputs are tied to zero.
module control_unit
   import ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             zero,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we,
   output logic             wez,
   output logic [2:0]       ALUOp,
   output logic             halted,
   output logic             trap,
   output logic [CNT_W-1:0] retired,
   output logic [CNT_W-1:0] taken
);

   state_t state;
   ctrl_t  dec_ctrl;
   ctrl_t  out_ctrl;
   logic   dec_halt;
   logic   dec_illegal;

   control_decode u_decode (
      .Opcode     (Opcode),
      .zero       (zero),
      .ctrl       (dec_ctrl),
      .is_halt    (dec_halt),
      .is_illegal (dec_illegal)
   );

   // Run-state register: HALT and TRAP are sticky until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_RUN;
      end else if (state == ST_RUN) begin
         if (dec_halt) begin
            state <= ST_HALT;
         end else if (dec_illegal) begin
            state <= ST_TRAP;
         end
      end
   end

   // Override mux: reset wins, then HALT/TRAP silence the datapath.
   always_comb begin
      out_ctrl = CTRL_RESET;
      if (!reset) begin
         case (state)
            ST_RUN:  out_ctrl = dec_ctrl;
            default: out_ctrl = CTRL_STOP;
         endcase
      end
   end

   assign s_inc  = out_ctrl.s_inc;
   assign s_inm  = out_ctrl.s_inm;
   assign we     = out_ctrl.we;
   assign wez    = out_ctrl.wez;
   assign ALUOp  = out_ctrl.alu_op;
   assign halted = !reset && (state == ST_HALT);
   assign trap   = !reset && (state == ST_TRAP);

`ifdef CTRL_PERF_EN
   // Performance counters: every RUN cycle retires one instruction; a RUN cycle
   // that does not advance the PC sequentially is a taken jump.
   always_ff @(posedge clk) begin
      if (reset) begin
         retired <= '0;
         taken   <= '0;
      end else if (state == ST_RUN) begin
         retired <= retired + 1'b1;
         if (!dec_ctrl.s_inc) begin
            taken <= taken + 1'b1;
         end
      end
   end
`else
   assign retired = '0;
   assign taken   = '0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit. Expected control vectors are
// queued as each step is driven and checked on the following falling edge.
module tb_control_unit;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic       s_inc;
      logic       s_inm;
      logic       we;
      logic       wez;
      logic [2:0] alu;
      logic       halted;
      logic       trap;
   } exp_t;

   // Commonly expected output rows.
   localparam exp_t E_RST  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
   localparam exp_t E_LI   = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0};
   localparam exp_t E_JMP  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
   localparam exp_t E_NOJ  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
   localparam exp_t E_HALT = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
   localparam exp_t E_TRAP = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1};

   logic             clk;
   logic             reset;
   logic [5:0]       Opcode;
   logic             zero;
   logic             s_inc;
   logic             s_inm;
   logic             we;
   logic             wez;
   logic [2:0]       ALUOp;
   logic             halted;
   logic             trap;
   logic [CNT_W-1:0] retired;
   logic [CNT_W-1:0] taken;

   exp_t  exp_q[$];
   string tag_q[$];
   int    compared;
   int    mismatched;

   control_unit #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .Opcode  (Opcode),
      .zero    (zero),
      .s_inc   (s_inc),
      .s_inm   (s_inm),
      .we      (we),
      .wez     (wez),
      .ALUOp   (ALUOp),
      .halted  (halted),
      .trap    (trap),
      .retired (retired),
      .taken   (taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected ALU R-type row for a given opcode.
   function automatic exp_t alu_row(input logic [5:0] op);
      exp_t e;
      e = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0};
      e.alu = op[4:2];
      return e;
   endfunction

   task automatic applyStimulus(input string tag, input logic r, input logic [5:0] op,
                                input logic z, input exp_t e);
      reset  = r;
      Opcode = op;
      zero   = z;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic checkOutput();
      exp_t  e;
      exp_t  obs;
      string tag;
      @(negedge clk);
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard: observed empty queue, required an entry");
      end else begin
         e   = exp_q.pop_front();
         tag = tag_q.pop_front();
         obs = '{s_inc, s_inm, we, wez, ALUOp, halted, trap};
         assert (obs === e) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed s_inc,s_inm,we,wez,alu,halted,trap=%b required %b", tag, obs, e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic r, input logic [5:0] op,
                       input logic z, input exp_t e);
      applyStimulus(tag, r, op, z, e);
      checkOutput();
   endtask

   task automatic check_counters(input string tag, input logic [CNT_W-1:0] exp_ret,
                                 input logic [CNT_W-1:0] exp_tkn);
      compared++;
      assert (retired === exp_ret && taken === exp_tkn) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed retired=%0d taken=%0d required retired=%0d taken=%0d",
                tag, retired, taken, exp_ret, exp_tkn);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      Opcode     = 6'b000000;
      zero       = 1'b0;

      // Reset held for three cycles, then load immediate.
      for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 6'b000000, 1'b0, E_RST);
      check_counters("cnt_after_reset", '0, '0);
      step("li_after_reset", 1'b0, 6'b000000, 1'b1, E_LI);
      step("li_low_bits", 1'b0, 6'b000011, 1'b0, E_LI);

      // ALU R-type rows.
      step("alu_011", 1'b0, 6'b101100, 1'b0, alu_row(6'b101100));
      step("alu_111", 1'b0, 6'b111111, 1'b1, alu_row(6'b111111));
      step("alu_000", 1'b0, 6'b100000, 1'b0, alu_row(6'b100000));

      // Jumps.
      step("jz_zero1", 1'b0, 6'b010100, 1'b1, E_JMP);
      step("jz_zero0", 1'b0, 6'b010100, 1'b0, E_NOJ);
      step("jnz_zero1", 1'b0, 6'b011000, 1'b1, E_NOJ);
      step("jnz_zero0", 1'b0, 6'b011000, 1'b0, E_JMP);
      step("j_plain", 1'b0, 6'b010000, 1'b1, E_JMP);
      step("j_low_bits", 1'b0, 6'b010011, 1'b0, E_JMP);

      // HALT is sticky until reset.
      step("halt_issue", 1'b0, 6'b011100, 1'b0, E_JMP);
      for (int i = 0; i < 5; i++) step("halt_sticky", 1'b0, 6'b100000, 1'b0, E_HALT);
      step("halt_reset", 1'b1, 6'b100000, 1'b0, E_RST);
      step("halt_resume", 1'b0, 6'b101100, 1'b0, alu_row(6'b101100));

      // Illegal opcodes trap and stay trapped.
      step("ill_0001", 1'b0, 6'b000100, 1'b0, E_NOJ);
      step("trap_alu", 1'b0, 6'b101100, 1'b0, E_TRAP);
      step("trap_halt_op", 1'b0, 6'b011100, 1'b1, E_TRAP);
      step("trap_reset", 1'b1, 6'b000000, 1'b0, E_RST);
      step("ill_0111_01", 1'b0, 6'b011101, 1'b0, E_NOJ);
      step("trap_again", 1'b0, 6'b000000, 1'b0, E_TRAP);
      step("trap_reset2", 1'b1, 6'b000000, 1'b0, E_RST);
      step("ill_0011", 1'b0, 6'b001111, 1'b1, E_NOJ);
      step("trap_third", 1'b0, 6'b010000, 1'b0, E_TRAP);
      step("trap_reset3", 1'b1, 6'b000000, 1'b0, E_RST);
      check_counters("cnt_cleared", '0, '0);

      // 17 RUN cycles with 3 taken jumps.
      for (int i = 0; i < 17; i++) begin
         if (i == 2 || i == 7 || i == 12) step("perf_j", 1'b0, 6'b010000, 1'b0, E_JMP);
         else step("perf_alu", 1'b0, 6'b100100, 1'b0, alu_row(6'b100100));
      end
`ifdef CTRL_PERF_EN
      check_counters("perf_wrap", 4'd1, 4'd3);
`else
      check_counters("perf_tied", '0, '0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
